// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
package arb_pkg;

    // Number of requesters and the matching mux select width.
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    // Arbiter state encodings.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t HOLD = 2'd1;
    localparam state_t GAP  = 2'd2;

    // One-hot grant vector for a select index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_select_arbiter_pick.sv
// Rotating-priority encoder: first set request after 'last', wrapping to 'last' itself.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
    always_comb begin
        idx  = '0;
        cand = last;
        any  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the registered select of a downstream 4:1 mux.
// Grants one source at a time, releases on request drop, done or hold timeout,
// and inserts one settle cycle between tenures.
module rr_select_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   select,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid,
    output logic               timeout
);

    // Timeout enable and the counter value on the final cycle of a tenure.
    localparam bit               TO_EN     = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [SEL_W-1:0] last;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             hold_expired;
    logic             release_c;
    logic             timeout_only;

    // Next owner under rotating priority, starting after the previous owner.
    rr_pick u_pick (
        .req  (req),
        .last (last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Release conditions while holding; timeout only flags a release nothing else caused.
    always_comb begin
        owner_req    = req[select];
        hold_expired = TO_EN && (hold_cnt == HOLD_LAST);
        release_c    = !owner_req || done || hold_expired;
        timeout_only = hold_expired && owner_req && !done;
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            select   <= '0;
            grant    <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last     <= SEL_W'(NUM_REQ - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_any) begin
                        grant    <= onehot(pick_idx);
                        select   <= pick_idx;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end else begin
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    if (release_c) begin
                        // select is left alone so the mux input does not glitch.
                        grant   <= '0;
                        valid   <= 1'b0;
                        last    <= select;
                        timeout <= timeout_only;
                        state   <= GAP;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
